// File: rtl/pattern_painter_if.sv
// pattern_painter_if
// Groups the pixel-request, mode-selection and painted-output signals of
// the pattern painter so the scanner side and the painter side connect
// through one port.
//   frame       : 13-bit frame counter from the scanner
//   subframe    : 8-bit PWM threshold (painter uses the low CBITS bits)
//   x, y        : pixel column / row, XY_BITS each
//   in_valid    : pixel request qualifier
//   mode_req    : requested pattern
//   mode_load   : one-cycle strobe capturing mode_req
//   rgb         : {blu, grn, red} PWM bits
//   out_valid   : rgb qualifier
//   mode_active : pattern currently painted
// master = requester (scanner / testbench), slave = pattern_painter.
interface pattern_painter_if #(
  parameter int XY_BITS = 6
);
  logic [12:0]        frame;
  logic [7:0]         subframe;
  logic [XY_BITS-1:0] x;
  logic [XY_BITS-1:0] y;
  logic               in_valid;
  logic [1:0]         mode_req;
  logic               mode_load;
  logic [2:0]         rgb;
  logic               out_valid;
  logic [1:0]         mode_active;

  modport master (
    output frame, subframe, x, y, in_valid, mode_req, mode_load,
    input  rgb, out_valid, mode_active
  );

  modport slave (
    input  frame, subframe, x, y, in_valid, mode_req, mode_load,
    output rgb, out_valid, mode_active
  );
endinterface

// File: rtl/pattern_painter.sv
// pattern_painter
// Two-stage pipelined test-pattern generator for the LED matrix driver.
// Stage 1 computes a CBITS-bit intensity per channel in one of four
// patterns (bars, gradient, checker, fade); stage 2 compares each
// intensity against the subframe threshold to give one PWM bit per
// channel. Pattern changes are deferred to the next frame boundary.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high, clears all registers
//   bus   : pattern_painter_if slave modport (requests in, rgb out)
module pattern_painter #(
  parameter int XY_BITS = 6,
  parameter int CBITS   = 4
) (
  input logic              clk,
  input logic              reset,
  pattern_painter_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_GRADIENT = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_FADE     = 2'd3
  } mode_e;

  localparam int L = 1 << XY_BITS;
  localparam logic [CBITS-1:0] FULL = '1;

  // Bar edges in the 13-bit scroll coordinate.
  localparam logic [12:0] RED_LO = 13'(5 * L);
  localparam logic [12:0] RED_HI = 13'(7 * L);
  localparam logic [12:0] GRN_LO = 13'((5 * L) / 2);
  localparam logic [12:0] GRN_HI = 13'((9 * L) / 2);
  localparam logic [12:0] BLU_HI = 13'(2 * L);

  mode_e       mode_active;
  mode_e       mode_pend;
  logic        pend_v;
  logic [12:0] frame_q;
  logic        boundary;

  logic [12:0]      xx;
  logic             chk;
  logic [CBITS-1:0] pr, pg, pb;

  logic             s1_v;
  logic [CBITS-1:0] ir, ig, ib, thr;

  logic [2:0] rgb;
  logic       out_valid;

  // Upper subframe bits and top frame bits are not used by any pattern.
  logic unused_bits;
  assign unused_bits = ^{bus.subframe, bus.frame};

  assign boundary = (bus.frame != frame_q);

  // Mode control: a load between boundaries is parked in mode_pend (last
  // load wins); at a boundary a same-cycle load takes priority over the
  // parked one, so the newest request is what gets painted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_active <= MODE_BARS;
      mode_pend   <= MODE_BARS;
      pend_v      <= 1'b0;
      frame_q     <= '0;
    end else begin
      frame_q <= bus.frame;
      if (boundary) begin
        if (bus.mode_load) begin
          mode_active <= mode_e'(bus.mode_req);
        end else if (pend_v) begin
          mode_active <= mode_pend;
        end
        pend_v <= 1'b0;
      end else if (bus.mode_load) begin
        mode_pend <= mode_e'(bus.mode_req);
        pend_v    <= 1'b1;
      end
    end
  end

  // Pattern intensities for the current request, using the mode that is
  // active in this cycle (so a boundary-cycle pixel keeps the old mode).
  always_comb begin
    xx  = RED_HI + 13'(bus.x) - {4'd0, bus.frame[10:2]};
    chk = bus.x[3] ^ bus.y[3] ^ bus.frame[6];
    pr  = '0;
    pg  = '0;
    pb  = '0;
    case (mode_active)
      MODE_BARS: begin
        pr = (xx >= RED_LO && xx < RED_HI) ? FULL : '0;
        pg = (xx >= GRN_LO && xx < GRN_HI) ? FULL : '0;
        pb = (xx < BLU_HI) ? FULL : '0;
      end
      MODE_GRADIENT: begin
        pr = bus.x[XY_BITS-1 -: CBITS];
        pg = bus.y[XY_BITS-1 -: CBITS];
        pb = bus.frame[CBITS+1:2];
      end
      MODE_CHECKER: begin
        pr = chk ? FULL : '0;
        pg = chk ? FULL : '0;
        pb = chk ? FULL : '0;
      end
      MODE_FADE: begin
        pr = bus.frame[CBITS+3:4];
        pg = bus.frame[CBITS+3:4];
        pb = bus.frame[CBITS+3:4];
      end
    endcase
  end

  // Stage 1: data registers only load on a valid request and hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v <= 1'b0;
      ir   <= '0;
      ig   <= '0;
      ib   <= '0;
      thr  <= '0;
    end else begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        ir  <= pr;
        ig  <= pg;
        ib  <= pb;
        thr <= bus.subframe[CBITS-1:0];
      end
    end
  end

  // Stage 2: strict greater-than, so intensity 0 never lights and full
  // scale lights for every threshold except full scale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      rgb       <= '0;
    end else begin
      out_valid <= s1_v;
      if (s1_v) begin
        rgb <= {(ib > thr), (ig > thr), (ir > thr)};
      end
    end
  end

  assign bus.rgb         = rgb;
  assign bus.out_valid   = out_valid;
  assign bus.mode_active = mode_active;

endmodule

// File: tb/tb_pattern_painter.sv
// tb_pattern_painter
// Scoreboard bench for pattern_painter (XY_BITS=6, CBITS=4). Each driven
// request pushes its expected rgb and due cycle; a negedge monitor pops and
// compares whenever out_valid is seen, and flags missing or stray outputs.
// mode_active is compared against a bench-side mode model every cycle.
module tb_pattern_painter;

  localparam int XY = 6;
  localparam int CB = 4;

  typedef struct {
    logic [2:0] rgb;
    int         due;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sbq[$];

  int mmode;
  int mpend;
  int mpend_v;
  int mframe_q;

  pattern_painter_if #(.XY_BITS(XY)) bus ();

  pattern_painter #(.XY_BITS(XY), .CBITS(CB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference pattern model written directly from the pattern definitions.
  function automatic logic [2:0] modelRgb(input int mode, input int frm, input int sub,
                                          input int px, input int py);
    int n;
    int l;
    int xx;
    int r;
    int g;
    int b;
    int c;
    int thr;
    n   = (1 << CB) - 1;
    l   = 1 << XY;
    thr = sub & n;
    r   = 0;
    g   = 0;
    b   = 0;
    case (mode)
      0: begin
        xx = (7 * l + px - ((frm >> 2) & 511)) & 8191;
        r  = (xx >= 5 * l && xx < 7 * l) ? n : 0;
        g  = (2 * xx >= 5 * l && 2 * xx < 9 * l) ? n : 0;
        b  = (xx < 2 * l) ? n : 0;
      end
      1: begin
        r = px >> (XY - CB);
        g = py >> (XY - CB);
        b = (frm >> 2) & n;
      end
      2: begin
        c = ((px >> 3) ^ (py >> 3) ^ (frm >> 6)) & 1;
        r = c ? n : 0;
        g = r;
        b = r;
      end
      default: begin
        r = (frm >> 4) & n;
        g = r;
        b = r;
      end
    endcase
    return {b > thr, g > thr, r > thr};
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.out_valid) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_valid", 1, 0);
        end else begin
          e = sbq.pop_front();
          checkOutput("rgb", bus.rgb, e.rgb);
          checkOutput("latency", cyc, e.due);
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        checkOutput("missing_valid", 0, 1);
        void'(sbq.pop_front());
      end
    end
  end

  // One cycle of stimulus: check mode, drive inputs, push expectation,
  // then advance the mode model at the sampling edge.
  task automatic applyStimulus(input logic load, input logic [1:0] req, input logic [12:0] frm,
                               input logic [7:0] sub, input int px, input int py,
                               input logic valid, input logic use_exp, input logic [2:0] exp_rgb);
    exp_t e;
    @(negedge clk);
    checkOutput("mode_active", bus.mode_active, mmode);
    #1;
    bus.mode_load = load;
    bus.mode_req  = req;
    bus.frame     = frm;
    bus.subframe  = sub;
    bus.x         = px[XY-1:0];
    bus.y         = py[XY-1:0];
    bus.in_valid  = valid;
    if (valid) begin
      e.rgb = use_exp ? exp_rgb : modelRgb(mmode, int'(frm), int'(sub), px, py);
      e.due = cyc + 2;
      sbq.push_back(e);
    end
    @(posedge clk);
    if (int'(frm) != mframe_q) begin
      if (load) mmode = int'(req);
      else if (mpend_v != 0) mmode = mpend;
      mpend_v = 0;
    end else if (load) begin
      mpend   = int'(req);
      mpend_v = 1;
    end
    mframe_q = int'(frm);
  endtask

  task automatic known(input logic [12:0] frm, input logic [7:0] sub, input int px, input int py,
                       input logic [2:0] exp_rgb);
    applyStimulus(1'b0, 2'd0, frm, sub, px, py, 1'b1, 1'b1, exp_rgb);
  endtask

  task automatic pixel(input logic [12:0] frm, input logic [7:0] sub, input int px, input int py);
    applyStimulus(1'b0, 2'd0, frm, sub, px, py, 1'b1, 1'b0, 3'b000);
  endtask

  task automatic loadMode(input logic [1:0] req, input logic [12:0] frm);
    applyStimulus(1'b1, req, frm, 8'd0, 0, 0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic idle(input logic [12:0] frm, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, frm, 8'd0, 0, 0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic doReset(input int n);
    @(negedge clk);
    #1;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mode_load = 1'b0;
    bus.frame     = '0;
    sbq.delete();
    mmode    = 0;
    mpend    = 0;
    mpend_v  = 0;
    mframe_q = 0;
    repeat (n) @(negedge clk);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_rgb", bus.rgb, 0);
    checkOutput("reset_mode_active", bus.mode_active, 0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    cyc           = 0;
    reset         = 1'b1;
    bus.frame     = '0;
    bus.subframe  = '0;
    bus.x         = '0;
    bus.y         = '0;
    bus.in_valid  = 1'b0;
    bus.mode_req  = '0;
    bus.mode_load = 1'b0;
    repeat (2) @(posedge clk);
    doReset(2);

    $display("[TB] reset and latency");
    known(13'd0, 8'd0, 0, 0, 3'b000);
    idle(13'd0, 4);

    $display("[TB] request cut off by reset");
    known(13'd0, 8'd0, 0, 0, 3'b000);
    doReset(2);
    idle(13'd0, 4);

    $display("[TB] bars");
    known(13'd4, 8'd0, 0, 0, 3'b001);
    known(13'd4, 8'd15, 0, 0, 3'b000);
    known(13'd4, 8'hF0, 0, 0, 3'b001);
    for (int i = 0; i < 12; i++)
      pixel(13'(i * 37), 8'($urandom_range(0, 255)), $urandom_range(0, 63), $urandom_range(0, 63));

    $display("[TB] deferred mode change");
    known(13'd4, 8'd0, 0, 0, 3'b001);
    loadMode(2'd2, 13'd4);
    known(13'd4, 8'd0, 0, 0, 3'b001);
    known(13'd4, 8'd0, 0, 0, 3'b001);
    known(13'd8, 8'd0, 0, 0, 3'b001);
    known(13'd8, 8'd0, 8, 0, 3'b111);

    $display("[TB] load at boundary");
    applyStimulus(1'b1, 2'd3, 13'd12, 8'd0, 0, 0, 1'b1, 1'b1, 3'b000);
    known(13'd12, 8'd0, 0, 0, 3'b000);
    known(13'd80, 8'd4, 0, 0, 3'b111);
    known(13'd80, 8'd5, 0, 0, 3'b000);

    $display("[TB] pending overwrite");
    loadMode(2'd1, 13'd80);
    loadMode(2'd2, 13'd80);
    idle(13'd80, 1);
    idle(13'd96, 1);
    known(13'd96, 8'd0, 8, 0, 3'b000);
    known(13'd96, 8'd0, 0, 0, 3'b111);

    $display("[TB] gradient");
    loadMode(2'd1, 13'd0);
    known(13'd0, 8'd7, 63, 0, 3'b001);
    known(13'd0, 8'd7, 63, 32, 3'b011);
    for (int i = 0; i < 10; i++)
      pixel(13'(i * 53 + 1), 8'($urandom_range(0, 255)), $urandom_range(0, 63), $urandom_range(0, 63));

    $display("[TB] checker streaming");
    loadMode(2'd2, 13'd0);
    for (int i = 0; i < 64; i++) known(13'd0, 8'd0, i, 0, ((i >> 3) & 1) != 0 ? 3'b111 : 3'b000);
    for (int i = 0; i < 64; i++) known(13'd64, 8'd0, i, 0, ((i >> 3) & 1) != 0 ? 3'b000 : 3'b111);
    for (int i = 0; i < 8; i++)
      pixel(13'd64, 8'($urandom_range(0, 255)), $urandom_range(0, 63), $urandom_range(0, 63));

    idle(13'd64, 6);
    checkOutput("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
